// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM encoding, handshake
// constants and result field positions, common to the divider and the EX stage.
package mdu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Result layout is {remainder, quotient}; the quotient always starts at bit 0.
  localparam int unsigned QuoLo = 0;

  function automatic int unsigned rem_hi(input int unsigned width);
    return 2 * width - 1;
  endfunction

  function automatic int unsigned rem_lo(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned quo_hi(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff = rem_i - {1'b0, divisor_i};
    // A set top bit means the trial subtraction borrowed.
    q_o   = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider with start/ready handshake, cancellation,
// divide-by-zero flag and signed operands via magnitude division plus sign fix.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned RemHi = rem_hi(WIDTH);
  localparam int unsigned RemLo = rem_lo(WIDTH);
  localparam int unsigned QuoHi = quo_hi(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dsr_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               dz_q;
  logic [2*WIDTH-1:0] result_q;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   fin_quo;
  logic [WIDTH-1:0]   fin_rem;

  // The dividend register doubles as the quotient: its MSB feeds the remainder
  // while the new quotient bit enters at the bottom.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    ({rem_q, quo_q[WIDTH-1]}),
    .divisor_i(dsr_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    accept    = (start_i == DivStart) && !annul_i;
    last_step = (cnt_q == LastCnt);
    op1_abs   = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_abs   = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    step_quo  = {quo_q[WIDTH-2:0], step_q};
    fin_quo   = q_neg_q ? -step_quo : step_quo;
    fin_rem   = r_neg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (accept) state_d = (opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
      end
      DIV_DIVZERO: state_d = annul_i ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (annul_i)        state_d = DIV_IDLE;
        else if (last_step) state_d = DIV_END;
      end
      DIV_END: begin
        if (annul_i || (start_i == DivStop)) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= op1_abs;
            dsr_q    <= op2_abs;
            q_neg_q  <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_q  <= signed_i & opdata1_i[WIDTH-1];
            dz_q     <= (opdata2_i == '0);
            result_q <= '0;
          end
        end
        DIV_ON: begin
          if (!annul_i) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            if (last_step) begin
              cnt_q                  <= '0;
              result_q[RemHi:RemLo]  <= fin_rem;
              result_q[QuoHi:QuoLo]  <= fin_quo;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_q == DIV_DIVZERO) || (state_q == DIV_ON);
    ready_o    = (state_q == DIV_END) ? DivResultReady : DivResultNotReady;
    div_zero_o = ready_o & dz_q;
    result_o   = ready_o ? result_q : '0;
  end

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed spec scenarios plus randomized
// operations against an arithmetic reference model, for WIDTH=32 and WIDTH=8.
module tb_mdu_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start8;
  logic        annul;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy, ready, dz;
  logic [63:0] result;
  logic        busy8, ready8, dz8;
  logic [15:0] result8;

  int checks = 0;
  int errors = 0;

  mdu_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .annul_i   (annul),
    .signed_i  (sgn),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .busy_o    (busy),
    .ready_o   (ready),
    .div_zero_o(dz),
    .result_o  (result)
  );

  mdu_div #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start8),
    .annul_i   (annul),
    .signed_i  (sgn),
    .opdata1_i (op1[7:0]),
    .opdata2_i (op2[7:0]),
    .busy_o    (busy8),
    .ready_o   (ready8),
    .div_zero_o(dz8),
    .result_o  (result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign-extend to 64 bits, use language division (truncating toward
  // zero, remainder takes dividend sign), reduce modulo 2^w.
  function automatic logic [63:0] model(input int w, input bit s, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] mask, ua, ub;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, a} & mask;
    ub = {32'b0, b} & mask;
    if (s && ua[w-1]) ua = ua | ~mask;
    if (s && ub[w-1]) ub = ub | ~mask;
    sa = $signed(ua);
    sb = $signed(ub);
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return (($unsigned(r) & mask) << w) | ($unsigned(q) & mask);
  endfunction

  // Runs one operation from the current negedge; returns observations only.
  task automatic run_div(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy, output bit leak,
                         output logic [63:0] res, output bit dzo);
    lat = 0; nbusy = 0; leak = 0; res = '0; dzo = 0;
    sgn = s; op1 = a; op2 = b;
    if (w8) start8 = 1'b1;
    else    start  = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      op1 = $urandom;
      op2 = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if (w8 ? busy8 : busy) nbusy++;
      if (w8 ? ready8 : ready) begin
        lat = c;
        res = w8 ? {48'b0, result8} : result;
        dzo = w8 ? dz8 : dz;
        break;
      end
      if ((w8 ? (result8 != 0) : (result != 0)) || (w8 ? dz8 : dz)) leak = 1;
    end
  endtask

  task automatic drop_start(input bit w8, output bit rdy_after);
    start  = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    rdy_after = w8 ? ready8 : ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ready, dz, result, busy8, ready8, dz8, result8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b ready=%b dz=%b res=%h want all 0",
               busy, ready, dz, result);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Directed operation: latency, busy cycles, no output leak, result and flag.
  task automatic test_op(input string name, input bit w8, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res,
                         input bit exp_dz);
    int lat, nb;
    bit lk, dzo, rdy;
    logic [63:0] res;
    logic [81:0] got, exp;
    run_div(w8, s, a, b, lat, nb, lk, res, dzo);
    got = {8'(lat), 8'(nb), lk, dzo, res};
    exp = {8'(exp_lat), 8'(exp_lat - 1), 1'b0, exp_dz, exp_res};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got lat=%0d busy=%0d leak=%b dz=%b res=%h want lat=%0d busy=%0d leak=0 dz=%b res=%h",
               name, lat, nb, lk, dzo, res, exp_lat, exp_lat - 1, exp_dz, exp_res);
    end
    drop_start(w8, rdy);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: ready got %b want 0", name, rdy);
    end
  endtask

  task automatic test_unsigned;
    test_op("unsigned_100_7", 0, 0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 0);
  endtask

  task automatic test_signed;
    test_op("signed_m7_2", 0, 1, -32'sd7, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
    test_op("signed_7_m2", 0, 1, 32'd7, -32'sd2, 33, {32'd1, 32'hFFFFFFFD}, 0);
  endtask

  task automatic test_div_zero;
    test_op("divzero_signed", 0, 1, 32'd5, 32'd0, 2, 64'd0, 1);
    test_op("divzero_unsigned", 0, 0, 32'd5, 32'd0, 2, 64'd0, 1);
  endtask

  task automatic test_overflow;
    test_op("ovf_signed", 0, 1, 32'h80000000, 32'hFFFFFFFF, 33, {32'd0, 32'h80000000}, 0);
    test_op("ovf_unsigned", 0, 0, 32'h80000000, 32'hFFFFFFFF, 33, {32'h80000000, 32'd0}, 0);
  endtask

  task automatic test_annul;
    bit saw_ready;
    saw_ready = 0;
    sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ready) saw_ready = 1;
    end
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({saw_ready, busy, ready} !== 3'b000) begin
      errors++;
      $display("FAIL annul_on: got saw_ready=%b busy=%b ready=%b want 0 0 0", saw_ready, busy, ready);
    end
    annul = 1'b0;
    test_op("after_annul_9_3", 0, 0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 0);

    // Start and annul together in IDLE: stays idle.
    sgn = 1'b0; op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ready} !== 2'b00) begin
      errors++;
      $display("FAIL annul_idle: got busy=%b ready=%b want 0 0", busy, ready);
    end
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ready, dz} !== 3'b000) begin
      errors++;
      $display("FAIL annul_divzero: got busy=%b ready=%b dz=%b want 0 0 0", busy, ready, dz);
    end
    annul = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold;
    int lat, nb, stable;
    bit lk, dzo, rdy;
    logic [63:0] res;
    run_div(0, 0, 32'd100, 32'd7, lat, nb, lk, res, dzo);
    stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready && result === {32'd2, 32'd14} && !dz) stable++;
    end
    checks++;
    if (stable != 5) begin
      errors++;
      $display("FAIL hold_stable: got %0d stable cycles want 5", stable);
    end
    drop_start(0, rdy);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL hold_drop: ready got %b want 0", rdy);
    end
  endtask

  task automatic test_reset_mid;
    sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ready, dz, result} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b ready=%b dz=%b res=%h want all 0",
               busy, ready, dz, result);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_width8;
    test_op("w8_200_9", 1, 0, 32'd200, 32'd9, 9, {48'd0, 8'd2, 8'd22}, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    bit s, w8, zero;
    int w;
    for (int i = 0; i < 24; i++) begin
      w8 = (i % 3 == 2);
      w  = w8 ? 8 : 32;
      s  = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      zero = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
      test_op("random", w8, s, a, b, zero ? 2 : w + 1, model(w, s, a, b), zero);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start8 = 1'b0; annul = 1'b0; sgn = 1'b0;
    op1 = '0; op2 = '0;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_hold();
    test_reset_mid();
    test_width8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
